rtg_campaign_ctrl: RTL and testbench

//  Hardware random-test-generation campaign sequencer for combinational benchmark CUTs.

---
 rtl/rtg_pkg.sv | 36 +++
 rtl/rtg_lfsr.sv | 31 +++
 rtl/rtg_campaign_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_rtg_campaign_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtg_pkg.sv
// Shared constants for the random-test-generation campaign sequencer:
// FSM state codes, default parameter values and LFSR tap masks.
package rtg_pkg;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_GEN  = 4'd1;
    localparam logic [3:0] ST_SCAN = 4'd2;
    localparam logic [3:0] ST_INJ  = 4'd3;
    localparam logic [3:0] ST_WAIT = 4'd4;
    localparam logic [3:0] ST_CMP  = 4'd5;
    localparam logic [3:0] ST_EVAL = 4'd6;
    localparam logic [3:0] ST_EMIT = 4'd7;
    localparam logic [3:0] ST_DONE = 4'd8;

    localparam int DEF_PI_W       = 50;
    localparam int DEF_PO_W       = 22;
    localparam int DEF_NUM_FAULTS = 2230;
    localparam int DEF_FID_W      = $clog2(DEF_NUM_FAULTS);
    localparam int DEF_CNT_W      = $clog2(DEF_NUM_FAULTS + 1);

    // Galois left-shift masks: bit i set for every x^i term below x^width.
    function automatic logic [63:0] defaultTaps(input int width);
        case (width)
            8:       return 64'h71;
            16:      return 64'hA011;
            32:      return 64'h0040_0007;
            50:      return 64'h2_0000_0180_0001;
            default: return (64'd1 << (width - 1)) | 64'd1;
        endcase
    endfunction

    function automatic logic [15:0] sat16Inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rtg_lfsr.sv
// Galois LFSR pattern source; a zero seed is replaced by 1 so the register
// can never lock up in the all-zero state.
module rtg_lfsr #(
    parameter int           W    = 50,
    parameter logic [W-1:0] TAPS = W'(1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] seed,
    output logic [W-1:0] stepValue
);

    logic [W-1:0] lfsrReg;

    always_comb begin
        stepValue = {lfsrReg[W-2:0], 1'b0} ^ (lfsrReg[W-1] ? TAPS : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsrReg <= W'(1);
        end else if (load) begin
            lfsrReg <= (seed == '0) ? W'(1) : seed;
        end else if (step) begin
            lfsrReg <= stepValue;
        end
    end

endmodule

// File: rtl/rtg_campaign_ctrl.sv
// Random-test-generation campaign sequencer: generates LFSR vectors, sweeps
// every still-undetected fault per vector, keeps vectors that detect enough.
//
//  state | meaning
//  IDLE  | waiting for start after reset
//  GEN   | step LFSR, latch new pattern, clear per-vector state
//  SCAN  | skip already-detected fault ids, one per cycle
//  INJ   | fault injected on the faulty copy
//  WAIT  | let the faulty copy settle for SETTLE cycles
//  CMP   | compare responses, record pending detection, drop injection
//  EVAL  | keep or reject the vector, merge pending detections
//  EMIT  | offer kept vector to the sink, then evaluate stop
//  DONE  | campaign finished, waiting for a new start
module rtg_campaign_ctrl
    import rtg_pkg::*;
#(
    parameter int               PI_W       = DEF_PI_W,
    parameter int               PO_W       = DEF_PO_W,
    parameter int               NUM_FAULTS = DEF_NUM_FAULTS,
    parameter int               EF_COUNT   = 1,
    parameter int               UT_LIMIT   = 50,
    parameter int               COV_PCT    = 95,
    parameter int               SETTLE     = 6,
    parameter logic [PI_W-1:0]  LFSR_TAPS  = PI_W'(defaultTaps(PI_W))
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [PI_W-1:0]                   seed,
    output logic [PI_W-1:0]                   pattern,
    output logic [$clog2(NUM_FAULTS)-1:0]     flt_id,
    output logic                              flt_inject,
    input  logic [PO_W-1:0]                   good_resp,
    input  logic [PO_W-1:0]                   bad_resp,
    output logic                              vec_valid,
    input  logic                              vec_ready,
    output logic [PI_W-1:0]                   vec_data,
    output logic                              busy,
    output logic                              done,
    output logic                              stop_cov,
    output logic [$clog2(NUM_FAULTS+1)-1:0]   det_total,
    output logic [15:0]                       kept_cnt,
    output logic [15:0]                       tried_cnt
);

    localparam int FID_W = $clog2(NUM_FAULTS);
    localparam int CNT_W = $clog2(NUM_FAULTS + 1);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [FID_W:0]  NF_IDX  = (FID_W + 1)'(NUM_FAULTS);
    localparam logic [CNT_W:0]  NF_CNT  = (CNT_W + 1)'(NUM_FAULTS);
    localparam logic [CNT_W:0]  EF_LIM  = (CNT_W + 1)'(EF_COUNT);
    localparam logic [15:0]     UT_LIM  = 16'(UT_LIMIT);
    localparam logic [39:0]     COV_RHS = 40'(COV_PCT) * 40'(NUM_FAULTS);

    logic [3:0]            state;
    logic [FID_W:0]        fltIdx;
    logic [NUM_FAULTS-1:0] detected;
    logic [NUM_FAULTS-1:0] pend;
    logic [CNT_W-1:0]      vecDet;
    logic [15:0]           useless;
    logic [SET_W-1:0]      waitCnt;
    logic [PI_W-1:0]       lfsrNext;
    logic [CNT_W:0]        detSum;
    logic                  lfsrLoad, lfsrStep;
    logic                  scanEnd, curDetected, keepVec, covHit, uselessHit;

    rtg_lfsr #(.W(PI_W), .TAPS(LFSR_TAPS)) uLfsr (
        .clk       (clk),
        .rst       (rst),
        .load      (lfsrLoad),
        .step      (lfsrStep),
        .seed      (seed),
        .stepValue (lfsrNext)
    );

    assign lfsrLoad    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign lfsrStep    = (state == ST_GEN);
    assign flt_id      = fltIdx[FID_W-1:0];
    assign busy        = (state != ST_IDLE) && (state != ST_DONE);
    assign done        = (state == ST_DONE);

    // A full bitmap ends the sweep at once instead of skipping id by id.
    assign scanEnd     = (fltIdx >= NF_IDX) || (&detected);
    assign curDetected = detected[fltIdx[FID_W-1:0]];
    assign keepVec     = ({1'b0, vecDet} >= EF_LIM);
    assign detSum      = {1'b0, det_total} + {1'b0, vecDet};
    // Widened so 100*det_total cannot overflow for large fault lists.
    assign covHit      = (40'(det_total) * 40'd100) >= COV_RHS;
    assign uselessHit  = (useless >= UT_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pattern    <= '0;
            fltIdx     <= '0;
            flt_inject <= 1'b0;
            vec_valid  <= 1'b0;
            vec_data   <= '0;
            stop_cov   <= 1'b0;
            det_total  <= '0;
            kept_cnt   <= '0;
            tried_cnt  <= '0;
            detected   <= '0;
            pend       <= '0;
            vecDet     <= '0;
            useless    <= '0;
            waitCnt    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        detected  <= '0;
                        det_total <= '0;
                        kept_cnt  <= '0;
                        tried_cnt <= '0;
                        useless   <= '0;
                        stop_cov  <= 1'b0;
                        state     <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    pattern   <= lfsrNext;
                    tried_cnt <= sat16Inc(tried_cnt);
                    useless   <= sat16Inc(useless);
                    vecDet    <= '0;
                    pend      <= '0;
                    fltIdx    <= '0;
                    state     <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (scanEnd) begin
                        state <= ST_EVAL;
                    end else if (curDetected) begin
                        fltIdx <= fltIdx + 1'b1;
                    end else begin
                        flt_inject <= 1'b1;
                        state      <= ST_INJ;
                    end
                end
                ST_INJ: begin
                    waitCnt <= SET_W'(SETTLE - 1);
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (waitCnt == '0) begin
                        state <= ST_CMP;
                    end else begin
                        waitCnt <= waitCnt - 1'b1;
                    end
                end
                ST_CMP: begin
                    if (good_resp != bad_resp) begin
                        pend[fltIdx[FID_W-1:0]] <= 1'b1;
                        vecDet                  <= vecDet + 1'b1;
                    end
                    flt_inject <= 1'b0;
                    fltIdx     <= fltIdx + 1'b1;
                    state      <= ST_SCAN;
                end
                ST_EVAL: begin
                    if (keepVec) begin
                        detected  <= detected | pend;
                        det_total <= (detSum > NF_CNT) ? NF_CNT[CNT_W-1:0] : detSum[CNT_W-1:0];
                        kept_cnt  <= sat16Inc(kept_cnt);
                        useless   <= '0;
                        vec_data  <= pattern;
                        vec_valid <= 1'b1;
                        state     <= ST_EMIT;
                    end else if (covHit || uselessHit) begin
                        stop_cov <= covHit;
                        state    <= ST_DONE;
                    end else begin
                        state <= ST_GEN;
                    end
                end
                ST_EMIT: begin
                    if (vec_ready) begin
                        vec_valid <= 1'b0;
                        if (covHit || uselessHit) begin
                            stop_cov <= covHit;
                            state    <= ST_DONE;
                        end else begin
                            state <= ST_GEN;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtg_campaign_ctrl.sv
// Bench for rtg_campaign_ctrl: two instances (EF=1 and EF=2) driven by stub
// CUTs, checked against a set-based campaign model.
module tb_rtg_campaign_ctrl;

    localparam int PI_W = 8;
    localparam int PO_W = 4;
    localparam int NF   = 8;
    localparam int UT   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic            startA, injA, vvA, vrA, busyA, doneA, scA;
    logic [7:0]      seedA, patA, vdA;
    logic [2:0]      fidA;
    logic [3:0]      goodA, badA, detA;
    logic [15:0]     keptA, triedA;

    logic            startB, injB, vvB, busyB, doneB, scB;
    logic [7:0]      seedB, patB, vdB;
    logic [2:0]      fidB;
    logic [3:0]      goodB, badB, detB;
    logic [15:0]     keptB, triedB;

    bit              stubMode;
    logic [7:0]      sMask;

    // Mode 0: fault k detectable whenever in sMask; mode 1: only if pattern bit k is set.
    always_comb begin
        goodA = patA[3:0] ^ 4'h5;
        badA  = goodA ^ {3'b000, injA && sMask[fidA] && (!stubMode || patA[fidA])};
        goodB = patB[3:0];
        badB  = goodB ^ {3'b000, injB && (fidB == 3'd3)};
    end

    rtg_campaign_ctrl #(.PI_W(PI_W), .PO_W(PO_W), .NUM_FAULTS(NF), .EF_COUNT(1),
                        .UT_LIMIT(UT), .COV_PCT(100), .SETTLE(2), .LFSR_TAPS(8'h71)) dutA (
        .clk(clk), .rst(rst), .start(startA), .seed(seedA), .pattern(patA),
        .flt_id(fidA), .flt_inject(injA), .good_resp(goodA), .bad_resp(badA),
        .vec_valid(vvA), .vec_ready(vrA), .vec_data(vdA), .busy(busyA), .done(doneA),
        .stop_cov(scA), .det_total(detA), .kept_cnt(keptA), .tried_cnt(triedA));

    rtg_campaign_ctrl #(.PI_W(PI_W), .PO_W(PO_W), .NUM_FAULTS(NF), .EF_COUNT(2),
                        .UT_LIMIT(UT), .COV_PCT(100), .SETTLE(2), .LFSR_TAPS(8'h71)) dutB (
        .clk(clk), .rst(rst), .start(startB), .seed(seedB), .pattern(patB),
        .flt_id(fidB), .flt_inject(injB), .good_resp(goodB), .bad_resp(badB),
        .vec_valid(vvB), .vec_ready(1'b1), .vec_data(vdB), .busy(busyB), .done(doneB),
        .stop_cov(scB), .det_total(detB), .kept_cnt(keptB), .tried_cnt(triedB));

    int         checks = 0;
    int         errors = 0;
    logic [7:0] patQ[$];
    logic [7:0] keptQ[$];
    logic [7:0] mPat[$];
    logic [7:0] mKept[$];
    logic [15:0] prevTried = '0;
    logic       prevInjB = 1'b0;
    int         injB3 = 0;
    int         injBAll = 0;
    bit         vvBSeen = 1'b0;

    always @(negedge clk) begin
        if (triedA != prevTried && triedA != 16'd0) patQ.push_back(patA);
        prevTried = triedA;
        if (vvA && vrA) keptQ.push_back(vdA);
        if (injB && !prevInjB) begin
            injBAll++;
            if (fidB == 3'd3) injB3++;
        end
        prevInjB = injB;
        if (vvB) vvBSeen = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pattern k of the campaign is seed * x^k modulo x^8+x^6+x^5+x^4+1.
    function automatic int unsigned mulX(input int unsigned v);
        int unsigned r;
        r = v << 1;
        if ((r & 32'h100) != 0) r = r ^ 32'h171;
        return r;
    endfunction

    task automatic model(input logic [7:0] seed, input bit mode, input logic [7:0] mask,
                         output int tried, output int kept, output int det, output bit cov);
        int unsigned v;
        logic [7:0]  detMask, newm, p;
        int          useless;
        v = (seed == 8'd0) ? 1 : int'(seed);
        detMask = '0; useless = 0; tried = 0; kept = 0; cov = 1'b0;
        mPat.delete(); mKept.delete();
        for (int g = 0; g < 500; g++) begin
            v = mulX(v);
            p = v[7:0];
            tried++; useless++;
            mPat.push_back(p);
            newm = mode ? (mask & p & ~detMask) : (mask & ~detMask);
            if ($countones(newm) >= 1) begin
                detMask = detMask | newm;
                kept++; useless = 0;
                mKept.push_back(p);
                if ($countones(detMask) * 100 >= 100 * NF) begin
                    cov = 1'b1;
                    break;
                end
            end
            if (useless >= UT) break;
        end
        det = $countones(detMask);
    endtask

    task automatic pulseStartA(input logic [7:0] seed);
        seedA = seed; startA = 1'b1;
        tick();
        startA = 1'b0;
    endtask

    task automatic waitDoneA();
        int n = 0;
        while (!doneA && n < 5000) begin
            tick();
            n++;
        end
        check("campaign_done", doneA, 1);
    endtask

    task automatic compareRun(input string tag, input logic [7:0] seed, input bit mode,
                              input logic [7:0] mask);
        int t, k, d, n;
        bit c;
        model(seed, mode, mask, t, k, d, c);
        check({tag, "_tried"}, triedA, t);
        check({tag, "_kept"}, keptA, k);
        check({tag, "_det"}, detA, d);
        check({tag, "_stopcov"}, scA, c);
        check({tag, "_busy"}, busyA, 0);
        check({tag, "_npat"}, patQ.size(), mPat.size());
        n = (patQ.size() < mPat.size()) ? patQ.size() : mPat.size();
        for (int i = 0; i < n; i++) check({tag, "_pat"}, patQ[i], mPat[i]);
        check({tag, "_nkept"}, keptQ.size(), mKept.size());
        n = (keptQ.size() < mKept.size()) ? keptQ.size() : mKept.size();
        for (int i = 0; i < n; i++) check({tag, "_vec"}, keptQ[i], mKept[i]);
    endtask

    task automatic runA(input string tag, input logic [7:0] seed, input bit mode,
                        input logic [7:0] mask, input bit midStart);
        stubMode = mode; sMask = mask;
        patQ.delete(); keptQ.delete();
        pulseStartA(seed);
        if (midStart) begin
            repeat (5) tick();
            if (busyA) pulseStartA(~seed);
        end
        waitDoneA();
        compareRun(tag, seed, mode, mask);
    endtask

    typedef struct {
        logic [7:0] seed;
        bit         mode;
        logic [7:0] mask;
        int         expTried;
        int         expKept;
        int         expDet;
        bit         expCov;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int         n;
        bit         found;
        logic       pi;
        logic [7:0] hold, rs, rm;
        int         stable;

        tbl[0] = '{8'h01, 1'b0, 8'hFF, 1, 1, 8, 1'b1};
        tbl[1] = '{8'h00, 1'b0, 8'h00, 3, 0, 0, 1'b0};
        tbl[2] = '{8'h01, 1'b0, 8'h0F, 4, 1, 4, 1'b0};
        tbl[3] = '{8'h5A, 1'b0, 8'h80, 4, 1, 1, 1'b0};

        rst = 1'b1; startA = 1'b0; startB = 1'b0; seedA = '0; seedB = '0;
        vrA = 1'b1; stubMode = 1'b0; sMask = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_pattern", patA, 0);
        check("rst_flt_id", fidA, 0);
        check("rst_inject", injA, 0);
        check("rst_vec_valid", vvA, 0);
        check("rst_vec_data", vdA, 0);
        check("rst_busy_done", {busyA, doneA, scA}, 0);
        check("rst_counters", {detA, keptA, triedA}, 0);

        for (int i = 0; i < 4; i++) begin
            runA($sformatf("tbl%0d", i), tbl[i].seed, tbl[i].mode, tbl[i].mask, 1'b0);
            check($sformatf("tbl%0d_exp_tried", i), triedA, tbl[i].expTried);
            check($sformatf("tbl%0d_exp_kept", i), keptA, tbl[i].expKept);
            check($sformatf("tbl%0d_exp_det", i), detA, tbl[i].expDet);
            check($sformatf("tbl%0d_exp_cov", i), scA, tbl[i].expCov);
            if (i == 0 && keptQ.size() > 0) check("first_vec_seed1", keptQ[0], 8'h02);
            if (i == 1) check("seed0_first_pat", (patQ.size() > 0) ? patQ[0] : 8'h00, 8'h02);
        end

        // Sink stalls for 10 cycles: vector must hold and transfer once.
        vrA = 1'b0; stubMode = 1'b0; sMask = 8'h0F;
        patQ.delete(); keptQ.delete();
        pulseStartA(8'h01);
        n = 0;
        while (!vvA && n < 2000) begin
            tick();
            n++;
        end
        check("stall_valid_seen", vvA, 1);
        hold = vdA;
        stable = 0;
        repeat (10) begin
            tick();
            if (vvA && vdA == hold) stable++;
        end
        check("stall_stable", stable, 10);
        check("stall_no_transfer", keptQ.size(), 0);
        vrA = 1'b1;
        waitDoneA();
        compareRun("stall", 8'h01, 1'b0, 8'h0F);

        for (int r = 0; r < 6; r++) begin
            rs = 8'($urandom_range(0, 255));
            rm = 8'($urandom_range(0, 255));
            runA($sformatf("rnd%0d", r), rs, 1'b1, rm, 1'b1);
        end

        // EF=2 with a single detectable fault: nothing may ever be kept.
        injB3 = 0; injBAll = 0; vvBSeen = 1'b0;
        seedB = 8'h01; startB = 1'b1;
        tick();
        startB = 1'b0;
        n = 0;
        while (!doneB && n < 5000) begin
            tick();
            n++;
        end
        check("ef2_done", doneB, 1);
        check("ef2_tried", triedB, 3);
        check("ef2_kept", keptB, 0);
        check("ef2_det", detB, 0);
        check("ef2_stopcov", scB, 0);
        check("ef2_fault3_rescanned", injB3, 3);
        check("ef2_injections", injBAll, 24);
        check("ef2_no_valid", vvBSeen, 0);

        // Reset while the faulty copy is settling.
        stubMode = 1'b0; sMask = 8'h0F;
        pulseStartA(8'h01);
        found = 1'b0; pi = injA; n = 0;
        while (!found && n < 3000) begin
            tick();
            n++;
            if (detA != 4'd0 && injA && !pi) found = 1'b1;
            pi = injA;
        end
        check("rstwait_reached", found, 1);
        tick();
        rst = 1'b1;
        tick();
        check("rstwait_inject", injA, 0);
        check("rstwait_busy", busyA, 0);
        check("rstwait_det", detA, 0);
        check("rstwait_valid", vvA, 0);
        check("rstwait_tried", triedA, 0);
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
